temp_sampler: RTL and testbench
===============================

TEMP_SAMPLER -- requirements
Module: temp_sampler

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SCLK half-period (legal range 1..255).
REQ-002 SHALL have parameter SAMPLE_PERIOD, default 1000, meaning clk cycles between conversion starts (legal: at least 34*CLK_DIV+2).
REQ-003 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1, enables periodic conversions.
REQ-006 SHALL have port cs_n, output, 1, sensor chip select, active low.
REQ-007 SHALL have port sclk, output, 1, sensor serial clock, idle low.
REQ-008 SHALL have port miso, input, 1, sensor serial data, MSB first.
REQ-009 SHALL have port sample, output, 8, latest temperature sample, unsigned degrees C; feeds the downstream buffer dataIn.
REQ-010 SHALL have port sample_valid, output, 1, one-cycle strobe marking a new sample.
REQ-011 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-012 SHALL have port fault, output, 1, sticky sensor-fault flag.

Function
REQ-013 SHALL run a period counter 0..SAMPLE_PERIOD-1 while en=1, wrapping to 0; with en=0, hold the counter at 0.
REQ-014 SHALL start a conversion on the cycle the counter equals SAMPLE_PERIOD-1 and the FSM is IDLE; the first conversion after reset or after en rises therefore starts SAMPLE_PERIOD-1 cycles later.
REQ-015 SHALL implement FSM states IDLE, SETUP, SHIFT, HOLD, DONE; IDLE->SETUP on start; SETUP->SHIFT after CLK_DIV cycles; SHIFT->HOLD after 16 bits; HOLD->DONE after CLK_DIV cycles; DONE->IDLE after 1 cycle.
REQ-016 SHALL drive cs_n low in SETUP, SHIFT and HOLD, high otherwise; busy equals cs_n inverted, plus DONE.
REQ-017 SHALL, in SHIFT, drive sclk low for CLK_DIV cycles then high for CLK_DIV cycles per bit, for 16 bits; total conversion 34*CLK_DIV+1 cycles start to sample_valid.
REQ-018 SHALL capture miso into a 16-bit shift register on the clk edge at which sclk goes high, MSB first.
REQ-019 SHALL decode frame: bit15 sign, bits[14:7] magnitude, bit2 fault, other bits ignored.
REQ-020 SHALL, in DONE with bit2=0: set sample to 0x00 if bit15=1 (negative clamp), else bits[14:7]; pulse sample_valid for exactly that cycle.
REQ-021 SHALL, in DONE with bit2=1: leave sample unchanged, keep sample_valid low, set fault to 1.
REQ-022 SHALL keep fault set until reset; a later good frame does not clear it.
REQ-023 SHALL finish an in-progress conversion when en falls mid-conversion, including its sample_valid; no further starts.
REQ-024 SHALL hold sample stable between strobes.

Reset
REQ-025 SHALL on reset force: state IDLE, cs_n=1, sclk=0, sample=0x00, sample_valid=0, busy=0, fault=0, period counter=0, shift register=0.
REQ-026 SHALL abort any conversion when reset asserts mid-frame; cs_n high and sclk low from the cycle after reset is sampled; no sample_valid for the aborted frame.

Configuration
REQ-027 SHALL support macro TEMP_SAMPLER_AVG_EN: when defined, sample = (prev + new + 1) >> 1 using a 9-bit sum, prev = last emitted sample; the first good frame after reset is emitted unfiltered; faulted frames do not update prev.
REQ-028 SHALL, without TEMP_SAMPLER_AVG_EN, emit the decoded value unfiltered and contain no averaging logic.

Verification
REQ-029 Reset, en=1, sensor frame 0x0C80 (25 C) -> cs_n falls at cycle 999, sample_valid at cycle 999+137, sample=0x19.
REQ-030 Frame 0x8C80 (negative) -> sample=0x00, sample_valid pulses, fault=0.
REQ-031 Frame 0x0C84 (fault bit) -> no sample_valid, sample unchanged, fault=1 and stays 1 after next good frame 0x1400.
REQ-032 Reset asserted at 8th SCLK rise -> next cycle cs_n=1, sclk=0, busy=0, no sample_valid; next conversion 999 cycles after reset release.
REQ-033 en dropped mid-frame with 0x1400 -> sample=0x28 with sample_valid, then cs_n stays high.
REQ-034 With TEMP_SAMPLER_AVG_EN, frames 0x0A00 then 0x0B00 -> sample 0x14 then 0x15.

Source files
------------

// File: rtl/temp_sampler.sv
// temp_sampler: periodically reads a 16-bit serial temperature sensor frame
// and presents the decoded temperature as an unsigned 8-bit sample.
//
// Parameters:
//   CLK_DIV       clk cycles per SCLK half-period (1..255)
//   SAMPLE_PERIOD clk cycles between conversion starts (>= 34*CLK_DIV+2)
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   en           enables periodic conversions
//   cs_n         sensor chip select, active low
//   sclk         sensor serial clock, idle low
//   miso         sensor serial data, MSB first
//   sample       latest temperature sample (unsigned degrees C)
//   sample_valid one-cycle strobe marking a new sample
//   busy         high while a conversion is in progress
//   fault        sticky sensor-fault flag
//
// Optional feature: define TEMP_SAMPLER_AVG_EN to emit the rounded average of
// the previous emitted sample and the newly decoded value.
module temp_sampler #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic       cs_n,
  output logic       sclk,
  input  logic       miso,
  output logic [7:0] sample,
  output logic       sample_valid,
  output logic       busy,
  output logic       fault
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int unsigned PCW = $clog2(SAMPLE_PERIOD);

  logic [2:0]     state_q, state_d;
  logic [PCW-1:0] cnt_q, cnt_d;
  logic [7:0]     div_q, div_d;
  logic           phase_q, phase_d;
  logic [3:0]     bit_q, bit_d;
  logic [15:0]    shift_q, shift_d;
  logic           cs_n_q, cs_n_d;
  logic           sclk_q, sclk_d;
  logic [7:0]     sample_q, sample_d;
  logic           valid_q, valid_d;
  logic           busy_q, busy_d;
  logic           fault_q, fault_d;
  logic           div_end;
  logic           start;
  logic [7:0]     decoded;
`ifdef TEMP_SAMPLER_AVG_EN
  logic           have_prev_q, have_prev_d;
  logic [8:0]     avg_sum;
`endif

  always_comb begin
    div_end = (div_q == 8'(CLK_DIV - 1));
    start   = en && (cnt_q == PCW'(SAMPLE_PERIOD - 1)) && (state_q == ST_IDLE);
    // Negative readings clamp to zero.
    decoded = shift_q[15] ? 8'h00 : shift_q[14:7];

    if (!en || cnt_q == PCW'(SAMPLE_PERIOD - 1)) cnt_d = '0;
    else                                          cnt_d = cnt_q + PCW'(1);

    state_d  = state_q;
    div_d    = div_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    sclk_d   = sclk_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    fault_d  = fault_q;
`ifdef TEMP_SAMPLER_AVG_EN
    have_prev_d = have_prev_q;
    avg_sum     = {1'b0, sample_q} + {1'b0, decoded} + 9'd1;
`endif

    case (state_q)
      ST_IDLE: begin
        div_d = '0;
        if (start) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        if (div_end) begin
          state_d = ST_SHIFT;
          div_d   = '0;
          phase_d = 1'b0;
          bit_d   = '0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      ST_SHIFT: begin
        if (div_end) begin
          div_d = '0;
          if (!phase_q) begin
            // Rising SCLK edge: sample miso on the same clk edge.
            phase_d = 1'b1;
            sclk_d  = 1'b1;
            shift_d = {shift_q[14:0], miso};
          end else begin
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            if (bit_q == 4'd15) state_d = ST_HOLD;
            else                bit_d   = bit_q + 4'd1;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      ST_HOLD: begin
        if (div_end) begin
          state_d = ST_DONE;
          div_d   = '0;
          // Result registered on entry to DONE so the strobe aligns with DONE.
          if (shift_q[2]) begin
            fault_d = 1'b1;
          end else begin
            valid_d = 1'b1;
`ifdef TEMP_SAMPLER_AVG_EN
            sample_d    = have_prev_q ? avg_sum[8:1] : decoded;
            have_prev_d = 1'b1;
`else
            sample_d = decoded;
`endif
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    cs_n_d = !((state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_HOLD));
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      phase_q  <= 1'b0;
      bit_q    <= '0;
      shift_q  <= '0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
`ifdef TEMP_SAMPLER_AVG_EN
      have_prev_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      fault_q  <= fault_d;
`ifdef TEMP_SAMPLER_AVG_EN
      have_prev_q <= have_prev_d;
`endif
    end
  end

  assign cs_n         = cs_n_q;
  assign sclk         = sclk_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_temp_sampler.sv
// tb_temp_sampler: directed bench for temp_sampler with default parameters
// (CLK_DIV=4, SAMPLE_PERIOD=1000). A behavioural sensor shifts out a chosen
// 16-bit frame MSB first, advancing one bit after each SCLK rise.
// Cycle 0 is the clock period following the last reset edge.
module tb_temp_sampler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       cs_n;
  logic       sclk;
  logic       miso;
  logic [7:0] sample;
  logic       sample_valid;
  logic       busy;
  logic       fault;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [15:0] frame = 16'h0000;
  int          idx   = -1;

  logic [7:0] m_prev = 8'h00;
  bit         m_have = 1'b0;

  temp_sampler #(.CLK_DIV(4), .SAMPLE_PERIOD(1000)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .cs_n         (cs_n),
    .sclk         (sclk),
    .miso         (miso),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  // Sensor model
  always @(negedge cs_n) idx = 15;
  always @(posedge sclk) idx = idx - 1;
  assign miso = (!cs_n && idx >= 0) ? frame[idx[3:0]] : 1'b0;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step();
    reset  = 1'b0;
    cyc    = 0;
    m_prev = 8'h00;
    m_have = 1'b0;
  endtask

  // Expected sample after a frame completes; faulted frames leave it alone.
  function automatic logic [7:0] model_emit(input logic [15:0] frm);
    logic [7:0] dec;
    logic [8:0] s;
    dec = frm[15] ? 8'h00 : frm[14:7];
    s   = '0;
    if (!frm[2]) begin
`ifdef TEMP_SAMPLER_AVG_EN
      if (m_have) begin
        s   = {1'b0, m_prev} + {1'b0, dec} + 9'd1;
        dec = s[8:1];
      end
`endif
      m_prev = dec;
      m_have = 1'b1;
    end
    return m_prev;
  endfunction

  // Runs one full conversion from idle; reports strobe count and last strobed value.
  task automatic convert(input logic [15:0] frm, output int pulses, output logic [7:0] last);
    int n;
    frame  = frm;
    pulses = 0;
    last   = sample;
    n      = 0;
    while (busy !== 1'b1 && n < 3000) begin step(); n++; end
    while (busy === 1'b1 && n < 3000) begin
      if (sample_valid === 1'b1) begin pulses++; last = sample; end
      step();
      n++;
    end
    check("conv_in_time", 32'(n < 3000), 32'd1);
  endtask

  initial begin
    int         pulses;
    int         rises;
    int         lowcnt;
    int         n;
    logic [7:0] last;
    logic [7:0] exp;
    logic       prev_sclk;

    frame = 16'h0C80;
    en    = 1'b1;
    do_reset();

    check("rst_cs_n",  32'(cs_n), 32'd1);
    check("rst_sclk",  32'(sclk), 32'd0);
    check("rst_sample", 32'(sample), 32'h00);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);

    // First conversion timing, frame 0x0C80 -> 25 C
    while (cyc < 999) step();
    check("cs_n_hi_c999", 32'(cs_n), 32'd1);
    step();
    check("cs_n_lo_c1000", 32'(cs_n), 32'd0);
    check("busy_c1000", 32'(busy), 32'd1);
    while (cyc < 1135) step();
    check("valid_lo_c1135", 32'(sample_valid), 32'd0);
    step();
    exp = model_emit(16'h0C80);
    check("valid_c1136", 32'(sample_valid), 32'd1);
    check("sample_25c", 32'(sample), 32'(exp));
    check("fault_25c", 32'(fault), 32'd0);
    step();
    check("valid_one_cycle", 32'(sample_valid), 32'd0);
    check("sample_hold", 32'(sample), 32'(exp));
    check("busy_after_done", 32'(busy), 32'd0);

    // Negative reading clamps to zero
    convert(16'h8C80, pulses, last);
    exp = model_emit(16'h8C80);
    check("neg_pulses", 32'(pulses), 32'd1);
    check("neg_sample", 32'(last), 32'(exp));
    check("neg_fault", 32'(fault), 32'd0);

    // Faulted frame: no strobe, sample unchanged, fault sticks
    convert(16'h0C84, pulses, last);
    exp = model_emit(16'h0C84);
    check("flt_pulses", 32'(pulses), 32'd0);
    check("flt_sample", 32'(sample), 32'(exp));
    check("flt_fault", 32'(fault), 32'd1);
    convert(16'h1400, pulses, last);
    exp = model_emit(16'h1400);
    check("flt_good_pulses", 32'(pulses), 32'd1);
    check("flt_good_sample", 32'(last), 32'(exp));
    check("fault_sticky", 32'(fault), 32'd1);

    // Reset at the 8th SCLK rise aborts the frame
    frame     = 16'h0C80;
    rises     = 0;
    n         = 0;
    prev_sclk = sclk;
    while (rises < 8 && n < 3000) begin
      step();
      n++;
      if (sclk === 1'b1 && prev_sclk === 1'b0) rises++;
      prev_sclk = sclk;
    end
    check("sclk_rise8_seen", 32'(rises), 32'd8);
    reset = 1'b1;
    step();
    check("abort_cs_n", 32'(cs_n), 32'd1);
    check("abort_sclk", 32'(sclk), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(sample_valid), 32'd0);
    check("abort_fault", 32'(fault), 32'd0);
    reset  = 1'b0;
    cyc    = 0;
    m_prev = 8'h00;
    m_have = 1'b0;
    frame  = 16'h1400;
    pulses = 0;
    while (cyc < 999) begin
      step();
      if (sample_valid === 1'b1) pulses++;
    end
    check("abort_no_strobe", 32'(pulses), 32'd0);
    check("restart_cs_n_c999", 32'(cs_n), 32'd1);
    step();
    check("restart_cs_n_c1000", 32'(cs_n), 32'd0);

    // en falls mid-frame: conversion completes, no further starts
    repeat (40) step();
    en     = 1'b0;
    pulses = 0;
    last   = sample;
    n      = 0;
    while (busy === 1'b1 && n < 3000) begin
      if (sample_valid === 1'b1) begin pulses++; last = sample; end
      step();
      n++;
    end
    exp = model_emit(16'h1400);
    check("endrop_pulses", 32'(pulses), 32'd1);
    check("endrop_sample", 32'(last), 32'(exp));
    lowcnt = 0;
    repeat (2500) begin
      step();
      if (cs_n !== 1'b1 || busy !== 1'b0) lowcnt++;
    end
    check("endrop_idle", 32'(lowcnt), 32'd0);

    // Two consecutive good frames after reset
    en = 1'b1;
    do_reset();
    convert(16'h0A00, pulses, last);
    exp = model_emit(16'h0A00);
    check("seq1_pulses", 32'(pulses), 32'd1);
    check("seq1_sample", 32'(last), 32'(exp));
    convert(16'h0B00, pulses, last);
    exp = model_emit(16'h0B00);
    check("seq2_pulses", 32'(pulses), 32'd1);
    check("seq2_sample", 32'(last), 32'(exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
